// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing the CDB between result producers
// Optional statistics counters are built when CDB_ARB_STATS_EN is defined.
module cdb_arbiter #(
    parameter int RoB_WIDTH = 3,
    parameter int N_REQ     = 3,
    parameter int PTR_W     = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         rdy_in,
    input  logic                         flush_signal,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*RoB_WIDTH-1:0]   req_index,
    input  logic [N_REQ*32-1:0]          req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         CDB_update_en,
    output logic [RoB_WIDTH-1:0]         CDB_update_index,
    output logic [31:0]                  CDB_update_data,
    output logic                         busy
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [N_REQ*32-1:0]          stat_grant_cnt,
    output logic [31:0]                  stat_conflict_cnt
`endif
);

    logic [N_REQ-1:0]     buf_valid_q;
    logic [N_REQ-1:0]     buf_valid_d;
    logic [RoB_WIDTH-1:0] buf_index_q [N_REQ];
    logic [31:0]          buf_data_q  [N_REQ];
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     rr_ptr_d;
    logic                 cdb_en_q;
    logic [RoB_WIDTH-1:0] cdb_index_q;
    logic [31:0]          cdb_data_q;

    logic                 active;
    logic                 found;
    logic [PTR_W-1:0]     winner;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     load;
    int                   cand;

    assign active = rdy_in && !flush_signal;

    // Scan only the holding buffers, starting at rr_ptr and wrapping modulo N_REQ.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        grant  = '0;
        cand   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!found && buf_valid_q[cand]) begin
                found  = 1'b1;
                winner = PTR_W'(cand);
            end
        end
        if (found) begin
            grant[winner] = 1'b1;
        end
    end

    always_comb begin
        req_ready   = '0;
        load        = '0;
        buf_valid_d = buf_valid_q;
        rr_ptr_d    = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = active && (!buf_valid_q[i] || grant[i]);
            load[i]      = req_valid[i] && req_ready[i];
            if (load[i]) begin
                buf_valid_d[i] = 1'b1;
            end else if (grant[i]) begin
                buf_valid_d[i] = 1'b0;
            end
        end
        if (found) begin
            rr_ptr_d = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            buf_valid_q <= '0;
            rr_ptr_q    <= '0;
            cdb_en_q    <= 1'b0;
            cdb_index_q <= '0;
            cdb_data_q  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                buf_index_q[i] <= '0;
                buf_data_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            if (flush_signal) begin
                buf_valid_q <= '0;
                cdb_en_q    <= 1'b0;
            end else begin
                buf_valid_q <= buf_valid_d;
                rr_ptr_q    <= rr_ptr_d;
                cdb_en_q    <= found;
                if (found) begin
                    cdb_index_q <= buf_index_q[winner];
                    cdb_data_q  <= buf_data_q[winner];
                end
                for (int i = 0; i < N_REQ; i++) begin
                    if (load[i]) begin
                        buf_index_q[i] <= req_index[i*RoB_WIDTH +: RoB_WIDTH];
                        buf_data_q[i]  <= req_data[i*32 +: 32];
                    end
                end
            end
        end
    end

    assign CDB_update_en    = cdb_en_q;
    assign CDB_update_index = cdb_index_q;
    assign CDB_update_data  = cdb_data_q;
    assign busy             = |buf_valid_q;

`ifdef CDB_ARB_STATS_EN
    logic [31:0] grant_cnt_q [N_REQ];
    logic [31:0] conflict_cnt_q;
    int          nvalid;

    always_comb begin
        nvalid = 0;
        for (int i = 0; i < N_REQ; i++) begin
            nvalid = nvalid + int'(buf_valid_q[i]);
        end
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            conflict_cnt_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else if (rdy_in) begin
            if (nvalid >= 2) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
            if (found && !flush_signal) begin
                grant_cnt_q[winner] <= grant_cnt_q[winner] + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign stat_grant_cnt[g*32 +: 32] = grant_cnt_q[g];
    end
    assign stat_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
    localparam int RW = 3;
    localparam int N  = 3;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            rdy_in;
    logic            flush_signal;
    logic [N-1:0]    req_valid;
    logic [N*RW-1:0] req_index;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            CDB_update_en;
    logic [RW-1:0]   CDB_update_index;
    logic [31:0]     CDB_update_data;
    logic            busy;
`ifdef CDB_ARB_STATS_EN
    logic [N*32-1:0] stat_grant_cnt;
    logic [31:0]     stat_conflict_cnt;
`endif

    cdb_arbiter #(.RoB_WIDTH(RW), .N_REQ(N), .PTR_W(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_signal(flush_signal),
        .req_valid(req_valid), .req_index(req_index), .req_data(req_data),
        .req_ready(req_ready), .CDB_update_en(CDB_update_en),
        .CDB_update_index(CDB_update_index), .CDB_update_data(CDB_update_data),
        .busy(busy)
`ifdef CDB_ARB_STATS_EN
        , .stat_grant_cnt(stat_grant_cnt), .stat_conflict_cnt(stat_conflict_cnt)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model: one slot per requester, a rotating priority start, and a
    // queue of broadcasts that must appear on the bus in order.
    typedef struct {
        logic [RW-1:0] idx;
        logic [31:0]   data;
    } bc_t;

    bit            mv [N];
    logic [RW-1:0] mi [N];
    logic [31:0]   md [N];
    int            mptr;
    bit            mcdb_en;
    bit            last_rdy;
    bc_t           exp_q[$];
    bc_t           held;

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (mv[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int w = pick();
        for (int i = 0; i < N; i++) begin
            r[i] = rdy_in && !flush_signal && (!mv[i] || w == i);
        end
        return r;
    endfunction

    function automatic bit any_full();
        bit a = 0;
        for (int i = 0; i < N; i++) a = a | mv[i];
        return a;
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        int w;
        logic [N-1:0] rd;
        if (rst_in) begin
            for (int i = 0; i < N; i++) mv[i] = 0;
            mptr = 0;
            mcdb_en = 0;
            last_rdy = 1;
            exp_q.delete();
        end else begin
            last_rdy = rdy_in;
            if (rdy_in) begin
                if (flush_signal) begin
                    for (int i = 0; i < N; i++) mv[i] = 0;
                    mcdb_en = 0;
                end else begin
                    w  = pick();
                    rd = exp_ready();
                    mcdb_en = (w >= 0);
                    if (w >= 0) begin
                        exp_q.push_back('{mi[w], md[w]});
                        mptr = (w + 1) % N;
                    end
                    for (int i = 0; i < N; i++) begin
                        if (req_valid[i] && rd[i]) begin
                            mv[i] = 1;
                            mi[i] = req_index[i*RW +: RW];
                            md[i] = req_data[i*32 +: 32];
                        end else if (w == i) begin
                            mv[i] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk_in) begin
        bc_t e;
        check("cdb_en", {63'd0, CDB_update_en}, {63'd0, mcdb_en});
        check("req_ready", {61'd0, req_ready}, {61'd0, exp_ready()});
        check("busy", {63'd0, busy}, {63'd0, any_full()});
        if (CDB_update_en) begin
            if (last_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cdb_unexpected actual=idx %0d data 0x%0h required=no broadcast",
                             CDB_update_index, CDB_update_data);
                end else begin
                    e = exp_q.pop_front();
                    check("cdb_index", {61'd0, CDB_update_index}, {61'd0, e.idx});
                    check("cdb_data", {32'd0, CDB_update_data}, {32'd0, e.data});
                    held = e;
                end
            end else begin
                check("cdb_hold_index", {61'd0, CDB_update_index}, {61'd0, held.idx});
                check("cdb_hold_data", {32'd0, CDB_update_data}, {32'd0, held.data});
            end
        end else if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL cdb_missing actual=no broadcast required=idx %0d data 0x%0h",
                     exp_q[0].idx, exp_q[0].data);
            exp_q.delete();
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(int i, logic [RW-1:0] idx, logic [31:0] d);
        req_valid[i] = 1'b1;
        req_index[i*RW +: RW] = idx;
        req_data[i*32 +: 32] = d;
    endtask

    logic          sv_en;
    logic [RW-1:0] sv_idx;
    logic [31:0]   sv_data;

    initial begin
        rst_in = 1; rdy_in = 1; flush_signal = 0;
        req_valid = '0; req_index = '0; req_data = '0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 0;
        #1;
        check("rst_en", {63'd0, CDB_update_en}, 64'd0);
        check("rst_index", {61'd0, CDB_update_index}, 64'd0);
        check("rst_data", {32'd0, CDB_update_data}, 64'd0);
        check("rst_ready", {61'd0, req_ready}, 64'h7);
        check("rst_busy", {63'd0, busy}, 64'd0);

        // three-way contention from rr_ptr = 0
        drive(0, 3'd1, 32'hA1); drive(1, 3'd2, 32'hB2); drive(2, 3'd3, 32'hC3);
        step(); req_valid = '0; #1;
        check("cont_ready12", {62'd0, req_ready[2:1]}, 64'd0);
        step(); check("cont_first", {61'd0, CDB_update_index}, 64'd1);
        step(); check("cont_second", {61'd0, CDB_update_index}, 64'd2);
        step(); check("cont_third", {61'd0, CDB_update_index}, 64'd3);
        check("cont_third_en", {63'd0, CDB_update_en}, 64'd1);
        step(); check("cont_done_en", {63'd0, CDB_update_en}, 64'd0);
        repeat (2) step();

        // single requester latency
        drive(1, 3'd5, 32'h1234);
        step(); req_valid = '0; #1;
        check("single_edge1_en", {63'd0, CDB_update_en}, 64'd0);
        step();
        check("single_edge2_en", {63'd0, CDB_update_en}, 64'd1);
        check("single_index", {61'd0, CDB_update_index}, 64'd5);
        check("single_data", {32'd0, CDB_update_data}, 64'h1234);
        step(); check("single_one_cycle", {63'd0, CDB_update_en}, 64'd0);
        repeat (2) step();

        // streaming on requester 0
        for (int k = 0; k < 8; k++) begin
            drive(0, 3'(k), $urandom);
            #1 check("stream_ready0", {63'd0, req_ready[0]}, 64'd1);
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // flush with buffers 0 and 2 full while a broadcast is pending
        drive(1, 3'd4, 32'h44);
        step(); req_valid = '0;
        drive(0, 3'd6, 32'h66); drive(2, 3'd7, 32'h77);
        step(); req_valid = '0;
        flush_signal = 1;
        step(); flush_signal = 0; #1;
        check("flush_en", {63'd0, CDB_update_en}, 64'd0);
        check("flush_busy", {63'd0, busy}, 64'd0);
        repeat (3) step();

        // freeze with buffer 1 full and a broadcast on the bus
        drive(0, 3'd2, 32'h22);
        step(); req_valid = '0;
        drive(1, 3'd6, 32'hF00D);
        step(); req_valid = '0;
        rdy_in = 0;
        sv_en = CDB_update_en; sv_idx = CDB_update_index; sv_data = CDB_update_data;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("freeze_ready", {61'd0, req_ready}, 64'd0);
            check("freeze_en", {63'd0, CDB_update_en}, {63'd0, sv_en});
            check("freeze_index", {61'd0, CDB_update_index}, {61'd0, sv_idx});
            check("freeze_data", {32'd0, CDB_update_data}, {32'd0, sv_data});
            step();
        end
        rdy_in = 1;
        step();
        check("resume_en", {63'd0, CDB_update_en}, 64'd1);
        check("resume_index", {61'd0, CDB_update_index}, 64'd6);
        check("resume_data", {32'd0, CDB_update_data}, 64'hF00D);
        repeat (2) step();

        // randomized traffic, including zero payloads, freezes and flushes
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 6);
                req_index[i*RW +: RW] = 3'($urandom);
                req_data[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            end
            rdy_in = ($urandom_range(0, 9) != 0);
            flush_signal = ($urandom_range(0, 19) == 0);
            step();
        end
        req_valid = '0; rdy_in = 1; flush_signal = 0;
        repeat (5) step();

        // asynchronous reset while broadcasting with an entry still buffered
        drive(0, 3'd1, 32'h11); drive(2, 3'd7, 32'hBEEF);
        step(); req_valid = '0;
        step();
        check("prereset_en", {63'd0, CDB_update_en}, 64'd1);
        check("prereset_busy", {63'd0, busy}, 64'd1);
        #2 rst_in = 1;
        #1;
        check("async_rst_en", {63'd0, CDB_update_en}, 64'd0);
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_index", {61'd0, CDB_update_index}, 64'd0);
        step(); rst_in = 0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between execution-side producers: the reservation-station ALU, the load/store buffer, and an optional third unit.
- Each producer gets a one-entry holding buffer with ready/valid backpressure.
- A round-robin arbiter picks one buffered result per cycle and drives it onto a registered CDB broadcast, which is consumed by the RoB, the reservation station and the load/store buffer.

Parameters:
- RoB_WIDTH, 3, RoB index width; the CDB index is RoB_WIDTH bits.
- N_REQ, 3, number of requesters, range 2..8; requester 0 = RS, 1 = LSB, 2 = spare.
- PTR_W, 2, round-robin pointer width; must satisfy 2^PTR_W >= N_REQ.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global enable; low = freeze.
- flush_signal  in  1  misprediction flush.
- req_valid  in  N_REQ  per-requester result valid.
- req_index  in  N_REQ*RoB_WIDTH  packed RoB indices; requester i occupies bits [i*RoB_WIDTH +: RoB_WIDTH].
- req_data  in  N_REQ*32  packed result data; requester i occupies bits [i*32 +: 32].
- req_ready  out  N_REQ  per-requester accept, combinational.
- CDB_update_en  out  1  broadcast valid, registered.
- CDB_update_index  out  RoB_WIDTH  broadcast RoB index, registered.
- CDB_update_data  out  32  broadcast data, registered.
- busy  out  1  OR of all holding-buffer valid bits.

Behaviour:
- Reset (asynchronous, rst_in=1):
  - all buf_valid = 0; rr_ptr = 0.
  - CDB_update_en = 0, CDB_update_index = 0, CDB_update_data = 0.
  - req_ready = all 1s once reset is released.
- Holding buffer i, per cycle:
  - req_ready[i] = rdy_in && !flush_signal && (!buf_valid[i] || grant[i]).
  - Handshake: a transfer occurs when req_valid[i] && req_ready[i] at the rising edge; buf_index/buf_data[i] load and buf_valid[i] <= 1.
  - If grant[i] occurs with no new transfer, buf_valid[i] <= 0.
  - Grant and reload in the same cycle sustain 1 result/cycle per requester.
- Arbitration (combinational on the buffers only, never on raw req_* inputs):
  - Scan buf_valid starting at rr_ptr, wrapping modulo N_REQ; the first set bit wins.
  - At most one grant per cycle.
  - On a grant, rr_ptr <= (winner+1) mod N_REQ. With no grant, rr_ptr holds.
- Output register, each enabled cycle:
  - CDB_update_en <= |grant.
  - If a grant occurs, index/data <= winner's buffer contents; otherwise index/data hold their previous values.
- Latency: req accepted at edge t, CDB_update_en high during cycle t+1→t+2 at the earliest (exactly 2 edges), provided no competitor wins first.
- Worst-case wait for a buffered entry: N_REQ-1 grants to others. Starvation-free.
- flush_signal=1 with rdy_in=1, at the edge:
  - all buf_valid <= 0; CDB_update_en <= 0; rr_ptr holds.
  - req_ready = 0 during the flush cycle, so no new entry is captured.
- rdy_in=0:
  - every register holds, including CDB_update_en and rr_ptr.
  - req_ready = 0; flush_signal is ignored.
- Reset mid-operation: buffered results are discarded immediately.
- Index 0 and data 0 are legal payloads; valid is carried only by buf_valid and CDB_update_en.

Optional Feature:
- Macro CDB_ARB_STATS_EN.
- Defined:
  - Adds ports stat_grant_cnt (out, N_REQ*32, per-requester count of grants) and stat_conflict_cnt (out, 32, count of cycles with ≥2 buf_valid set).
  - Counters wrap modulo 2^32, are cleared by reset, hold while rdy_in=0, and are NOT cleared by flush.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single requester: req1 valid, index=5, data=0x1234 for one cycle → CDB_update_en=1, index=5, data=0x1234 exactly 2 edges later, for one cycle only.
- Three-way contention with rr_ptr=0: all three valid in the same cycle (idx 1/2/3) → broadcasts in order idx1, idx2, idx3 on consecutive cycles; req_ready[1] and req_ready[2] low while their buffers wait.
- Streaming: req0 valid every cycle, idx 0..7 → one broadcast per cycle in order, req_ready[0] constantly 1, rr_ptr stays 1.
- Flush: buffers 0 and 2 full when flush_signal=1 → next cycle CDB_update_en=0, busy=0; neither result is ever broadcast.
- Freeze: rdy_in=0 for 4 cycles with buffer 1 full → outputs unchanged and req_ready=0 throughout; broadcast resumes on the edge after rdy_in returns to 1.
- Async reset: assert rst_in mid-cycle with CDB_update_en=1 → CDB_update_en=0 immediately without waiting for a clock edge; busy=0.
